// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, ALU op
// classes, datapath mux selects and the main-controller state codes.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Codes 10/11 exist only when the addi extension is built in.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_e;

endpackage

// File: rtl/mc_main_control.sv
// Multicycle MIPS main controller: Moore outputs from the state register,
// with mem_ready gating the memory states. Optional addi path: MC_MAIN_CONTROL_ADDI_EN.
module mc_main_control
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_beq,
  output logic       pc_write_bne,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  state_e state_q, state_d;
  logic   mr;
  logic   op_legal;

  assign mr      = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
  assign state_o = state_q;

  always_comb begin
    op_legal = 1'b0;
    case (opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J: op_legal = 1'b1;
`ifdef MC_MAIN_CONTROL_ADDI_EN
      OP_ADDI: op_legal = 1'b1;
`endif
      default: op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mr ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_RTYPE:       state_d = S_EXEC;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
`ifdef MC_MAIN_CONTROL_ADDI_EN
          OP_ADDI:        state_d = S_ADDIEX;
`endif
          default:        state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mr ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mr ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
`ifdef MC_MAIN_CONTROL_ADDI_EN
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write     = 1'b0;
    pc_write_beq = 1'b0;
    pc_write_bne = 1'b0;
    iord         = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    mem_to_reg   = 1'b0;
    reg_dst      = 1'b0;
    reg_write    = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = SRCB_REG;
    alu_op       = ALUOP_ADD;
    pc_source    = PCSRC_ALU;
    illegal_op   = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mr;
        pc_write  = mr;
      end
      S_DECODE: begin
        alu_src_b  = SRCB_IMM_SH2;
        illegal_op = ~op_legal;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a    = 1'b1;
        alu_op       = ALUOP_SUB;
        pc_source    = PCSRC_ALUOUT;
        pc_write_beq = (opcode == OP_BEQ);
        pc_write_bne = (opcode == OP_BNE);
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
`ifdef MC_MAIN_CONTROL_ADDI_EN
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: reg_write = 1'b1;
`endif
      default: ;
    endcase
    // Reset aborts the instruction: no architectural write in the reset cycle.
    if (reset) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      illegal_op = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_main_control.sv
// Bench for mc_main_control: per-instruction expected cycle traces from the
// instruction-level rules, compared against the DUT every cycle.
module tb_mc_main_control;

  localparam logic [5:0] O_R   = 6'b000000;
  localparam logic [5:0] O_LW  = 6'b100011;
  localparam logic [5:0] O_SW  = 6'b101011;
  localparam logic [5:0] O_BEQ = 6'b000100;
  localparam logic [5:0] O_BNE = 6'b000101;
  localparam logic [5:0] O_J   = 6'b000010;
  localparam logic [5:0] O_ADDI = 6'b001000;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_beq, pc_write_bne, iord, mem_read, mem_write;
  logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state_o;

  int tests = 0;
  int fails = 0;
  logic [21:0] exp_q[$];
  logic [21:0] act;

  mc_main_control #(.MEM_HANDSHAKE(1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_beq(pc_write_beq), .pc_write_bne(pc_write_bne),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .state_o(state_o)
  );

  always #5 clk = ~clk;

  assign act = {state_o, pc_write, pc_write_beq, pc_write_bne, iord, mem_read,
                mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                alu_src_b, alu_op, pc_source, illegal_op};

  function automatic logic [21:0] mk(
    input logic [3:0] st, input logic pcw, input logic beq, input logic bne,
    input logic io, input logic mrd, input logic mwr, input logic irw,
    input logic m2r, input logic rdst, input logic rw, input logic asa,
    input logic [1:0] asb, input logic [1:0] aop, input logic [1:0] psrc,
    input logic ill);
    return {st, pcw, beq, bne, io, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc, ill};
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    if (op == O_R || op == O_LW || op == O_SW || op == O_BEQ || op == O_BNE || op == O_J)
      return 1'b1;
`ifdef MC_MAIN_CONTROL_ADDI_EN
    if (op == O_ADDI) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic check(input string name, input logic [21:0] got, input logic [21:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic want);
    check(name, {21'd0, got}, {21'd0, want});
  endtask

  // One clock cycle: drive inputs, queue the outputs the cycle must show.
  task automatic cyc(input logic rs, input logic mr, input logic [5:0] op,
                     input logic [21:0] e, inout int n);
    @(negedge clk);
    reset     = rs;
    mem_ready = mr;
    opcode    = op;
    #1 exp_q.push_back(e);
    n++;
  endtask

  // Expected cycle trace of one whole instruction.
  task automatic run_instr(input logic [5:0] op, input int sf, input int sm, output int n);
    logic r;
    n = 0;
    for (int i = 0; i < sf; i++)
      cyc(0, 0, 6'($urandom), mk(0,0,0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0), n);
    cyc(0, 1, 6'($urandom), mk(0,1,0,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0), n);
    r = 1'($urandom);
    cyc(0, r, op, mk(1,0,0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,~is_legal(op)), n);
    if (!is_legal(op)) return;
    if (op == O_LW || op == O_SW) begin
      cyc(0, 1'($urandom), op, mk(2,0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), n);
      if (op == O_LW) begin
        for (int i = 0; i < sm; i++)
          cyc(0, 0, op, mk(3,0,0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0), n);
        cyc(0, 1, op, mk(3,0,0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0), n);
        cyc(0, 1'($urandom), op, mk(4,0,0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0), n);
      end else begin
        for (int i = 0; i < sm; i++)
          cyc(0, 0, op, mk(5,0,0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0), n);
        cyc(0, 1, op, mk(5,0,0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0), n);
      end
    end else if (op == O_R) begin
      cyc(0, 1'($urandom), op, mk(6,0,0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0), n);
      cyc(0, 1'($urandom), op, mk(7,0,0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0), n);
    end else if (op == O_BEQ || op == O_BNE) begin
      cyc(0, 1'($urandom), op,
          mk(8,0,op == O_BEQ,op == O_BNE,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0), n);
    end else if (op == O_J) begin
      cyc(0, 1'($urandom), op, mk(9,1,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0), n);
    end else begin
      cyc(0, 1'($urandom), op, mk(10,0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), n);
      cyc(0, 1'($urandom), op, mk(11,0,0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0), n);
    end
  endtask

  always @(negedge clk) begin
    logic [21:0] e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cycle", act, e);
    end
  end

  initial begin
    int n;
    logic [5:0] op;
    logic [5:0] ops[8];
    ops = '{O_R, O_LW, O_SW, O_BEQ, O_BNE, O_J, O_ADDI, 6'b111111};

    reset = 1'b1; mem_ready = 1'b1; opcode = 6'd0;
    @(posedge clk);
    n = 0;
    cyc(1, 1, 6'd0, mk(0,0,0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0), n);
    cyc(1, 1, 6'd0, mk(0,0,0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0), n);
    #1;
    check1("reset_pc_write", pc_write, 1'b0);
    check1("reset_ir_write", ir_write, 1'b0);

    run_instr(O_LW, 0, 0, n);
    check("lw_cycles", 22'(n), 22'd5);
    run_instr(O_SW, 0, 3, n);
    check("sw_stall_cycles", 22'(n), 22'd7);
    run_instr(O_R, 0, 0, n);
    check("r_cycles", 22'(n), 22'd4);
    run_instr(O_BEQ, 0, 0, n);
    check("beq_cycles", 22'(n), 22'd3);
    run_instr(O_BNE, 0, 0, n);
    check("bne_cycles", 22'(n), 22'd3);
    run_instr(O_J, 0, 0, n);
    check("j_cycles", 22'(n), 22'd3);
    run_instr(6'b111111, 0, 0, n);
    check("illegal_cycles", 22'(n), 22'd2);
    run_instr(O_ADDI, 0, 0, n);
`ifdef MC_MAIN_CONTROL_ADDI_EN
    check("addi_cycles", 22'(n), 22'd4);
`else
    check("addi_illegal_cycles", 22'(n), 22'd2);
`endif

    // Directed literal after the fetch that follows reset.
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b1; opcode = O_J;
    #1;
    check1("fetch_mem_read", mem_read, 1'b1);
    check1("fetch_ir_write", ir_write, 1'b1);
    check1("fetch_pc_write", pc_write, 1'b1);
    n = 0;
    cyc(0, 1, O_J, mk(1,0,0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0), n);
    cyc(0, 1, O_J, mk(9,1,0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0), n);

    // Reset during a stalled store.
    n = 0;
    cyc(0, 1, 6'd0, mk(0,1,0,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0), n);
    cyc(0, 1, O_SW, mk(1,0,0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0), n);
    cyc(0, 1, O_SW, mk(2,0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), n);
    cyc(0, 0, O_SW, mk(5,0,0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0), n);
    cyc(1, 0, O_SW, mk(5,0,0,0,1,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0), n);
    cyc(0, 1, O_SW, mk(0,1,0,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0), n);
    cyc(0, 1, O_LW, mk(1,0,0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0), n);
    cyc(0, 1, O_LW, mk(2,0,0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), n);
    cyc(0, 1, O_LW, mk(3,0,0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0), n);
    cyc(0, 1, O_LW, mk(4,0,0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0), n);

    // Randomized instruction stream with memory stalls.
    for (int k = 0; k < 400; k++) begin
      int idx;
      idx = $urandom_range(0, 7);
      op = ops[idx];
      if (idx == 7) begin
        op = 6'($urandom);
        while (is_legal(op)) op = 6'($urandom);
      end
      run_instr(op, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                $urandom_range(0, 3), n);
    end

    repeat (3) @(negedge clk);
    #3;
    check("queue_drained", 22'(exp_q.size()), 22'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
